clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_meter_pkg.sv | 15 +
 rtl/clk_period_meter_if.sv | 14 +
 rtl/sync_edge_det.sv | 23 ++
 rtl/clk_period_meter.sv | 121 ++++++++++++
 tb/tb_clk_period_meter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and default parameters for the clock period meter.
package clk_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } meter_state_t;

   localparam int DEF_CNT_W       = 27;
   localparam int DEF_EXP_PERIOD  = 50_000_000;
   localparam int DEF_TOL         = 500;
   localparam int DEF_TIMEOUT_CYC = 100_000_000;

endpackage

// File: rtl/clk_period_meter_if.sv
// Result bundle of the period meter: the meter drives it (master), consumers read it (slave).
interface clk_period_meter_if
   import clk_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic [CNT_W-1:0] period_out;
   logic             period_vld;
   logic             in_range;
   logic             timeout;

   modport master (output period_out, period_vld, in_range, timeout);
   modport slave  (input  period_out, period_vld, in_range, timeout);
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; rise pulses for one clk on each synchronized 0->1 edge.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);
   logic s1, s2, hist;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         hist <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         hist <= s2;
      end
   end

   assign rise = s2 & ~hist;
endmodule

// File: rtl/clk_period_meter.sv
// Measures the clk-cycle spacing between rising edges of sig_in, with range check and loss detection.
// Optional build macro CLK_PERIOD_METER_AVG_EN reports the mean of the last four captures instead.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
   parameter int TOL         = DEF_TOL,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sig_in,
   clk_period_meter_if.master mtr
);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W:0]   RANGE_LO = (CNT_W+1)'((EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0);
   localparam logic [CNT_W:0]   RANGE_HI = (CNT_W+1)'(EXP_PERIOD + TOL);

   logic             rise;
   meter_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cap;
   logic             capture, expire;
   logic [CNT_W-1:0] rep_val;
   logic             rep_vld;

   logic [CNT_W-1:0] period_q;
   logic             vld_q, inr_q, to_q;

   sync_edge_det u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sig_in),
      .rise  (rise)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A rise wins over the timeout check so a period of exactly TIMEOUT_CYC is still captured.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:           if (rise) state_nxt = ARMED;
         ARMED, MEASURE: begin
            if (rise)                     state_nxt = MEASURE;
            else if (cnt == TO_LAST)      state_nxt = IDLE;
         end
         default:        state_nxt = IDLE;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      expire  = 1'b0;
      if (state != IDLE) begin
         capture = rise;
         expire  = !rise && (cnt == TO_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                       cnt <= '0;
      else if (rise)                    cnt <= '0;
      else if (state == IDLE || expire) cnt <= '0;
      else if (cnt != CNT_MAX)          cnt <= cnt + 1'b1;
   end

   assign cap = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef CLK_PERIOD_METER_AVG_EN
   // Four-sample window: the capture in flight plus the three previous ones held here.
   logic [2:0][CNT_W-1:0] hist;
   logic [1:0]            fill;
   logic [CNT_W+1:0]      sum;

   assign sum     = (CNT_W+2)'(cap) + (CNT_W+2)'(hist[0]) + (CNT_W+2)'(hist[1]) + (CNT_W+2)'(hist[2]);
   assign rep_val = CNT_W'(sum >> 2);
   assign rep_vld = capture && (fill == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n || expire) begin
         hist <= '0;
         fill <= '0;
      end else if (capture) begin
         hist <= {hist[1:0], cap};
         if (fill != 2'd3) fill <= fill + 1'b1;
      end
   end
`else
   assign rep_val = cap;
   assign rep_vld = capture;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_q <= '0;
         vld_q    <= 1'b0;
         inr_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         vld_q <= rep_vld;
         if (rep_vld) begin
            period_q <= rep_val;
            inr_q    <= ({1'b0, rep_val} >= RANGE_LO) && ({1'b0, rep_val} <= RANGE_HI);
            to_q     <= 1'b0;
         end else if (expire) begin
            to_q     <= 1'b1;
         end
      end
   end

   assign mtr.period_out = period_q;
   assign mtr.period_vld = vld_q;
   assign mtr.in_range   = inr_q;
   assign mtr.timeout    = to_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter against an edge-spacing reference model.
module tb_clk_period_meter;
   localparam int CNT_W       = 27;
   localparam int EXP_PERIOD  = 100;
   localparam int TOL         = 2;
   localparam int TIMEOUT_CYC = 250;

   typedef struct {
      int p;
      bit inr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sig_in = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   exp_t exp_q[$];
   int   win[$];
   bit   armed = 1'b0;
   int   last_t = 0;
   bit   exp_to = 1'b0;
   int   last_out = 0;
   bit   last_inr = 1'b0;

   clk_period_meter_if #(.CNT_W(CNT_W)) mif ();

   clk_period_meter #(
      .CNT_W       (CNT_W),
      .EXP_PERIOD  (EXP_PERIOD),
      .TOL         (TOL),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .mtr    (mif)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_inr(input int p);
      return (p >= EXP_PERIOD - TOL) && (p <= EXP_PERIOD + TOL);
   endfunction

   // Reference: a rise within TIMEOUT_CYC of the previous one yields a period; otherwise it only arms.
   function automatic void model_rise(input int t);
      int p;
      int s;
      if (armed && (t - last_t) <= TIMEOUT_CYC) begin
         p = t - last_t;
`ifdef CLK_PERIOD_METER_AVG_EN
         win.push_back(p);
         if (win.size() > 4) void'(win.pop_front());
         if (win.size() == 4) begin
            s = 0;
            foreach (win[i]) s += win[i];
            p = s / 4;
         end else begin
            p = -1;
         end
`else
         s = 0;
`endif
         if (p >= 0) begin
            exp_q.push_back('{p: p, inr: model_inr(p)});
            last_out = p;
            last_inr = model_inr(p);
            exp_to   = 1'b0;
         end
      end else begin
         win.delete();
      end
      armed  = 1'b1;
      last_t = t;
   endfunction

   function automatic void model_reset();
      armed    = 1'b0;
      win.delete();
      exp_to   = 1'b0;
      last_out = 0;
      last_inr = 1'b0;
   endfunction

   // Rise now (3 ns after an edge), then hold for n cycles so the next rise lands n cycles later.
   task automatic pulse_period(input int n);
      int h;
      h = n / 2;
      sig_in = 1'b1;
      model_rise(cyc);
      repeat (h) @(posedge clk);
      #3 sig_in = 1'b0;
      repeat (n - h) @(posedge clk);
      #3;
      if (armed && n > TIMEOUT_CYC) begin
         exp_to = 1'b1;
         armed  = 1'b0;
         win.delete();
      end
      chk("held_period", 32'(mif.period_out), 32'(last_out));
      chk("held_in_range", 32'(mif.in_range), 32'(last_inr));
      if (!(n > TIMEOUT_CYC && n <= TIMEOUT_CYC + 5))
         chk("timeout_flag", 32'(mif.timeout), 32'(exp_to));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, 32'(mif.period_out), 32'd0);
      chk({tag, "_vld"}, 32'(mif.period_vld), 32'd0);
      chk({tag, "_in_range"}, 32'(mif.in_range), 32'd0);
      chk({tag, "_timeout"}, 32'(mif.timeout), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && mif.period_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_vld: got period %0d, expected no pulse (cycle %0d)",
                     mif.period_out, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("vld_period", 32'(mif.period_out), 32'(e.p));
            chk("vld_in_range", 32'(mif.in_range), 32'(e.inr));
            chk("vld_timeout_clr", 32'(mif.timeout), 32'd0);
         end
      end
   end

   initial begin
      #(20 * 100000);
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
      $fatal(1, "watchdog");
   end

   int directed[] = '{100, 100, 100, 100, 100, 98, 102, 97, 103, 100,
                      104, 96, 100, 108, 250, 251, 300, 100, 100, 100, 100, 100};

   initial begin
      int n;
      int r;
      repeat (3) @(posedge clk);
      #3;
      model_reset();
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #3;

      foreach (directed[i]) pulse_period(directed[i]);

      // Reset 60 cycles into a count; the following rise must only re-arm.
      sig_in = 1'b1;
      model_rise(cyc);
      repeat (50) @(posedge clk);
      #3 sig_in = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      chk_zero("midreset");
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #3;
      for (int k = 0; k < 6; k++) pulse_period(100);

      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      n = TIMEOUT_CYC + int'($urandom_range(0, 1));
         else if (r == 1) n = TIMEOUT_CYC + 20 + int'($urandom_range(0, 30));
         else             n = int'($urandom_range(94, 106));
         pulse_period(n);
      end
      pulse_period(100);

      repeat (10) @(posedge clk);
      #3;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
